alu_operand_seq: RTL and testbench
==================================

# alu_operand_seq

Operand-entry sequencer that sits directly upstream of the ALU on the FPGA board build. It turns board switches and push-buttons into the ALU's `port_A`, `port_B` and `alu_op` inputs. Each push-button is synchronized and debounced. The block then steps through an operand-capture state machine and holds the captured values stable for the ALU and the display LEDs.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive synchronized cycles a key level must hold before it is accepted (10 ms at 50 MHz); legal range ≥ 2.
- `SIGN_EXTEND`, default 0: 0 zero-extends the 17-bit switch value to 32 bits; 1 sign-extends from `sw_data[16]`.
- `CLK` in 1: single clock, rising edge.
- `nRST` in 1: reset, asynchronous and active-low.
- `sw_data` in 17: raw switch value (SW[16:0]); quasi-static, not synchronized.
- `key_n` in 2: raw push-buttons, active-low. Bit 0 is ADVANCE, bit 1 is CLEAR.
- `port_a` out 32 (`word_t`): captured operand A.
- `port_b` out 32 (`word_t`): captured operand B.
- `alu_op` out 4 (`aluop_t`): captured opcode.
- `op_valid` out 1: high while in state SHOW.
- `state_o` out 2: current state encoding, for the green LEDs.

## Operation
- Key path, per key:
  - 2-flop synchronizer.
  - Debounce counter. It increments each cycle the synced level differs from the debounced level, and clears whenever they are equal.
  - When the counter reaches `DEBOUNCE_CYCLES-1` and the levels still differ, the debounced level flips on the next edge and the counter clears.
- Press strobe: a registered one-cycle pulse, asserted in the cycle after the debounced level falls 1→0. Release produces no strobe. A held key produces exactly one strobe.
- FSM states and encodings: LOAD_A=2'd0, LOAD_B=2'd1, LOAD_OP=2'd2, SHOW=2'd3.
- On an ADVANCE strobe:
  - LOAD_A: `port_a` ← ext(`sw_data`); go to LOAD_B.
  - LOAD_B: `port_b` ← ext(`sw_data`); go to LOAD_OP.
  - LOAD_OP: `alu_op` ← `sw_data[3:0]`; go to SHOW.
  - SHOW: go to LOAD_A. Registers are kept, so the old operands stay visible until overwritten.
- On a CLEAR strobe, from any state: go to LOAD_A and zero `port_a`, `port_b` and `alu_op`.
- ADVANCE and CLEAR strobes in the same cycle: CLEAR wins and ADVANCE is discarded.
- `op_valid` = (state == SHOW), driven combinationally from the state register.
- ext() rules:
  - `SIGN_EXTEND`=0: {15'h0, sw_data}.
  - `SIGN_EXTEND`=1: {{15{sw_data[16]}}, sw_data}.
- `sw_data` is sampled only on the edge that consumes a strobe. Switch changes at any other time have no effect on the outputs.

## Timing
- Reset values (asynchronous on `nRST` low):
  - `port_a`=0, `port_b`=0, `alu_op`=4'h0, state=LOAD_A, `op_valid`=0, `state_o`=2'd0.
  - Synchronizer flops and debounced levels = 1 (released); counters = 0; strobes = 0.
- Reset asserted mid-debounce or mid-sequence discards all progress. A key still held low at reset release must debounce fresh and then yields one strobe.
- Latency: `key_n` falls just before edge E0 and stays low. Then:
  - synced level low after edge E1;
  - debounced level low after edge E1+`DEBOUNCE_CYCLES`;
  - strobe high during the following cycle;
  - register/state update at edge E0+`DEBOUNCE_CYCLES`+3.
- Glitches: any low or high excursion shorter than `DEBOUNCE_CYCLES` synced cycles produces no level change and no strobe.
- Re-press: needs a debounced release (≥ `DEBOUNCE_CYCLES` high) before the next strobe can occur.
- All outputs are registered, or decoded from registered state only, with no combinational path from inputs.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- Reset and bounce rejection: after reset all outputs are 0. Pulse `key_n[0]` low for 3 cycles, 5 times → no state change, `state_o`=0.
- Full sequence with `SIGN_EXTEND`=0:
  - `sw_data`=17'h1_2345, press/release ADVANCE → `port_a`=32'h0001_2345 exactly 7 edges after the press.
  - `sw_data`=17'h0_0007, ADVANCE → `port_b`=32'h7.
  - `sw_data`=17'h0_0004, ADVANCE → `alu_op`=4'h4, `op_valid`=1, `state_o`=3.
- Sign extension with `SIGN_EXTEND`=1: `sw_data`=17'h1_FFFF captured in LOAD_A → `port_a`=32'hFFFF_FFFF. `sw_data`=17'h0_FFFF → 32'h0000_FFFF.
- Hold and wrap: hold ADVANCE low for 100 cycles → exactly one transition. In SHOW, ADVANCE → `state_o`=0, `op_valid`=0, and `port_a`/`port_b`/`alu_op` unchanged.
- Simultaneous keys: from LOAD_OP with `port_a`=5, press both keys on the same cycle → state LOAD_A and all outputs 0.
- Async reset: in LOAD_B, drop `nRST` between clock edges → all outputs 0 before the next edge. With ADVANCE held low through reset release → exactly one strobe, 7 edges after release.

Source files
------------

// File: rtl/alu_operand_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_seq
// Purpose  : Operand-entry sequencer in front of the ALU. Two active-low
//            push-buttons are synchronized and debounced into one-cycle press
//            strobes. A four-state capture FSM loads operand A, operand B and
//            the opcode from the board switches. The captured values are held
//            stable for the ALU and the LEDs.
// Ports    : CLK       - single clock, rising edge
//            nRST      - asynchronous active-low reset
//            sw_data   - raw 17-bit switch value (quasi-static)
//            key_n     - raw buttons, active-low; [0]=ADVANCE, [1]=CLEAR
//            port_a    - captured operand A (32 bits)
//            port_b    - captured operand B (32 bits)
//            alu_op    - captured opcode (4 bits)
//            op_valid  - high while the FSM is in SHOW
//            state_o   - current state encoding for the green LEDs
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_seq #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit SIGN_EXTEND     = 1'b0
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [16:0] sw_data,
    input  logic [1:0]  key_n,
    output logic [31:0] port_a,
    output logic [31:0] port_b,
    output logic [3:0]  alu_op,
    output logic        op_valid,
    output logic [1:0]  state_o
);

    // The counter only has to reach DEBOUNCE_CYCLES-1, so clog2 is wide enough.
    localparam int                 c_CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        LOAD_OP = 2'd2,
        SHOW    = 2'd3
    } state_t;

    logic [1:0]  w_press;
    logic [31:0] w_ext;

    state_t      r_state;
    logic [31:0] r_port_a;
    logic [31:0] r_port_b;
    logic [3:0]  r_alu_op;

    // ------------------------------------------------------------------------
    // Per-key synchronizer, debouncer and press-strobe generator.
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < 2; k++) begin : g_key
        logic               r_sync1;
        logic               r_sync2;
        logic               r_deb;
        logic               r_deb_d;
        logic               r_press;
        logic [c_CNT_W-1:0] r_cnt;

        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                r_sync1 <= 1'b1;
                r_sync2 <= 1'b1;
                r_deb   <= 1'b1;
                r_deb_d <= 1'b1;
                r_press <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_sync1 <= key_n[k];
                r_sync2 <= r_sync1;

                // Any agreement between the synced and debounced level restarts
                // the count, so only an unbroken run can flip the level.
                if (r_sync2 == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CNT_MAX) begin
                    r_deb <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end

                // Falling-edge detect on the debounced level. A release gives no pulse.
                r_deb_d <= r_deb;
                r_press <= r_deb_d & ~r_deb;
            end
        end

        assign w_press[k] = r_press;
    end

    // ------------------------------------------------------------------------
    // Switch-value extension to the ALU word width.
    // ------------------------------------------------------------------------
    if (SIGN_EXTEND) begin : g_sext
        assign w_ext = {{15{sw_data[16]}}, sw_data};
    end else begin : g_zext
        assign w_ext = {15'h0000, sw_data};
    end

    // ------------------------------------------------------------------------
    // Capture FSM. CLEAR has priority: a simultaneous ADVANCE is dropped.
    // In SHOW, ADVANCE wraps to LOAD_A and keeps the old operands visible.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= LOAD_A;
            r_port_a <= '0;
            r_port_b <= '0;
            r_alu_op <= '0;
        end else if (w_press[1]) begin
            r_state  <= LOAD_A;
            r_port_a <= '0;
            r_port_b <= '0;
            r_alu_op <= '0;
        end else if (w_press[0]) begin
            case (r_state)
                LOAD_A: begin
                    r_port_a <= w_ext;
                    r_state  <= LOAD_B;
                end
                LOAD_B: begin
                    r_port_b <= w_ext;
                    r_state  <= LOAD_OP;
                end
                LOAD_OP: begin
                    r_alu_op <= sw_data[3:0];
                    r_state  <= SHOW;
                end
                default: begin
                    r_state  <= LOAD_A;
                end
            endcase
        end
    end

    assign port_a   = r_port_a;
    assign port_b   = r_port_b;
    assign alu_op   = r_alu_op;
    assign op_valid = (r_state == SHOW);
    assign state_o  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_seq
// Purpose  : Self-checking bench for alu_operand_seq. It drives one
//            zero-extending instance and one sign-extending instance from the
//            same inputs. Both instances are compared every cycle against a
//            behavioural model, and targeted checks cover the key scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_seq;

    localparam int D = 4;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [16:0] sw_data = '0;
    logic [1:0]  key_n = 2'b11;

    logic [31:0] pa0, pb0, pa1, pb1;
    logic [3:0]  op0, op1;
    logic        v0, v1;
    logic [1:0]  s0, s1;

    alu_operand_seq #(.DEBOUNCE_CYCLES(D), .SIGN_EXTEND(1'b0)) u_dut0 (
        .CLK(CLK), .nRST(nRST), .sw_data(sw_data), .key_n(key_n),
        .port_a(pa0), .port_b(pb0), .alu_op(op0), .op_valid(v0), .state_o(s0)
    );

    alu_operand_seq #(.DEBOUNCE_CYCLES(D), .SIGN_EXTEND(1'b1)) u_dut1 (
        .CLK(CLK), .nRST(nRST), .sw_data(sw_data), .key_n(key_n),
        .port_a(pa1), .port_b(pb1), .alu_op(op1), .op_valid(v1), .state_o(s1)
    );

    initial forever #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model.
    // A key level is accepted once D consecutive synced samples disagree with
    // it. A falling acceptance yields one press that the FSM consumes two edges
    // later.
    // ------------------------------------------------------------------------
    bit          m_s1[2], m_s2[2], m_deb[2], m_fell[2], m_press[2];
    bit          m_hist[2][D];
    int          m_fill[2];
    int          m_state;
    logic [16:0] m_a, m_b;
    logic [3:0]  m_op;
    bit          rand_sw = 1'b0;

    function automatic logic [31:0] ext(input logic [16:0] v, input bit se);
        logic [31:0] r;
        r = 32'(v);
        if (se && v >= 17'h10000) r = r + 32'hFFFE_0000;
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_s1[k] = 1'b1; m_s2[k] = 1'b1; m_deb[k] = 1'b1;
            m_fell[k] = 1'b0; m_press[k] = 1'b0; m_fill[k] = 0;
        end
        m_state = 0; m_a = '0; m_b = '0; m_op = '0;
    endtask

    task automatic model_edge();
        bit consume[2];
        bit all_diff;
        for (int k = 0; k < 2; k++) begin
            consume[k] = m_press[k];
            m_press[k] = m_fell[k];
            for (int i = D - 1; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
            m_hist[k][0] = m_s2[k];
            if (m_fill[k] < D) m_fill[k]++;
            all_diff = (m_fill[k] == D);
            for (int i = 0; i < D; i++) if (m_hist[k][i] == m_deb[k]) all_diff = 1'b0;
            m_fell[k] = all_diff && m_deb[k];
            if (all_diff) begin
                m_deb[k]  = ~m_deb[k];
                m_fill[k] = 0;
            end
            m_s2[k] = m_s1[k];
            m_s1[k] = key_n[k];
        end
        if (consume[1]) begin
            m_state = 0; m_a = '0; m_b = '0; m_op = '0;
        end else if (consume[0]) begin
            case (m_state)
                0: m_a  = sw_data;
                1: m_b  = sw_data;
                2: m_op = sw_data[3:0];
                default: ;
            endcase
            m_state = (m_state + 1) % 4;
        end
    endtask

    task automatic compare_all();
        check_eq("d0_port_a",   pa0, ext(m_a, 1'b0));
        check_eq("d0_port_b",   pb0, ext(m_b, 1'b0));
        check_eq("d0_alu_op",   32'(op0), 32'(m_op));
        check_eq("d0_op_valid", 32'(v0), (m_state == 3) ? 32'd1 : 32'd0);
        check_eq("d0_state",    32'(s0), 32'(m_state));
        check_eq("d1_port_a",   pa1, ext(m_a, 1'b1));
        check_eq("d1_port_b",   pb1, ext(m_b, 1'b1));
        check_eq("d1_alu_op",   32'(op1), 32'(m_op));
        check_eq("d1_op_valid", 32'(v1), (m_state == 3) ? 32'd1 : 32'd0);
        check_eq("d1_state",    32'(s1), 32'(m_state));
    endtask

    // One clock: model the edge, then compare on the falling edge where
    // inputs may also change.
    task automatic tick();
        @(posedge CLK);
        if (!nRST) model_reset();
        else       model_edge();
        @(negedge CLK);
        compare_all();
        if (rand_sw) sw_data = 17'($urandom);
    endtask

    task automatic press(input int k, input int hold, input int gap);
        key_n[k] = 1'b0;
        repeat (hold) tick();
        key_n[k] = 1'b1;
        repeat (gap) tick();
    endtask

    int prev_state;

    initial begin
        model_reset();
        repeat (3) tick();
        check_eq("rst_port_a",   pa0, 32'h0);
        check_eq("rst_port_b",   pb0, 32'h0);
        check_eq("rst_alu_op",   32'(op0), 32'h0);
        check_eq("rst_op_valid", 32'(v0), 32'h0);
        check_eq("rst_state",    32'(s0), 32'h0);
        nRST = 1'b1;
        repeat (2) tick();

        // Bounce rejection: 3-cycle low pulses never get accepted.
        for (int i = 0; i < 5; i++) begin
            key_n[0] = 1'b0;
            repeat (3) tick();
            key_n[0] = 1'b1;
            repeat ($urandom_range(1, 3)) tick();
        end
        repeat (D + 4) tick();
        check_eq("bounce_state", 32'(s0), 32'h0);

        // Full sequence with exact capture latency.
        sw_data  = 17'h1_2345;
        key_n[0] = 1'b0;
        repeat (7) tick();
        check_eq("lat_before", pa0, 32'h0);
        tick();
        check_eq("lat_edge7", pa0, 32'h0001_2345);
        key_n[0] = 1'b1;
        repeat (D + 5) tick();
        sw_data = 17'h0_0007;
        press(0, D + 4, D + 5);
        check_eq("seq_port_b", pb0, 32'h7);
        sw_data = 17'h0_0004;
        press(0, D + 4, D + 5);
        check_eq("seq_alu_op", 32'(op0), 32'h4);
        check_eq("seq_op_valid", 32'(v0), 32'h1);
        check_eq("seq_state", 32'(s0), 32'h3);

        // Sign extension.
        press(1, D + 4, D + 5);
        sw_data = 17'h1_FFFF;
        press(0, D + 4, D + 5);
        check_eq("sext_neg", pa1, 32'hFFFF_FFFF);
        check_eq("zext_neg", pa0, 32'h0001_FFFF);
        press(1, D + 4, D + 5);
        sw_data = 17'h0_FFFF;
        press(0, D + 4, D + 5);
        check_eq("sext_pos", pa1, 32'h0000_FFFF);

        // Long hold gives exactly one transition.
        prev_state = m_state;
        press(0, 100, D + 5);
        check_eq("hold_one", 32'(s0), 32'((prev_state + 1) % 4));

        // Wrap from SHOW keeps the operands.
        press(1, D + 4, D + 5);
        sw_data = 17'h0_0AAA; press(0, D + 4, D + 5);
        sw_data = 17'h1_0001; press(0, D + 4, D + 5);
        sw_data = 17'h0_0009; press(0, D + 4, D + 5);
        check_eq("wrap_in_show", 32'(s0), 32'h3);
        sw_data = 17'h1_5555; press(0, D + 4, D + 5);
        check_eq("wrap_state",    32'(s0), 32'h0);
        check_eq("wrap_op_valid", 32'(v0), 32'h0);
        check_eq("wrap_port_a",   pa0, 32'h0000_0AAA);
        check_eq("wrap_port_b",   pb1, 32'hFFFF_0001);
        check_eq("wrap_alu_op",   32'(op0), 32'h9);

        // Simultaneous keys: CLEAR wins.
        press(1, D + 4, D + 5);
        sw_data = 17'h0_0005; press(0, D + 4, D + 5);
        sw_data = 17'h0_0033; press(0, D + 4, D + 5);
        check_eq("simul_pre", 32'(s0), 32'h2);
        key_n = 2'b00;
        repeat (D + 5) tick();
        check_eq("simul_state",  32'(s0), 32'h0);
        check_eq("simul_port_a", pa0, 32'h0);
        check_eq("simul_port_b", pb0, 32'h0);
        key_n = 2'b11;
        repeat (D + 5) tick();

        // Randomized traffic, including boundary hold and gap lengths.
        rand_sw = 1'b1;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: press(0, $urandom_range(D - 1, D + 6), $urandom_range(D - 1, D + 6));
                6, 7:             press(1, $urandom_range(D - 1, D + 6), $urandom_range(D - 1, D + 6));
                default: begin
                    key_n = 2'b00;
                    repeat ($urandom_range(D - 1, D + 6)) tick();
                    key_n = 2'b11;
                    repeat ($urandom_range(D - 1, D + 6)) tick();
                end
            endcase
        end
        rand_sw = 1'b0;
        repeat (D + 5) tick();

        // Asynchronous reset in LOAD_B, with ADVANCE held through release.
        press(1, D + 4, D + 5);
        sw_data = 17'h1_1111;
        press(0, D + 4, D + 5);
        check_eq("ar_pre_state", 32'(s0), 32'h1);
        key_n[0] = 1'b0;
        #2 nRST = 1'b0;
        model_reset();
        #1;
        check_eq("ar_port_a",   pa0, 32'h0);
        check_eq("ar_port_b",   pb0, 32'h0);
        check_eq("ar_alu_op",   32'(op0), 32'h0);
        check_eq("ar_op_valid", 32'(v0), 32'h0);
        check_eq("ar_state",    32'(s0), 32'h0);
        @(negedge CLK);
        repeat (3) tick();
        nRST = 1'b1;
        repeat (7) tick();
        check_eq("ar_rel_before", 32'(s0), 32'h0);
        tick();
        check_eq("ar_rel_edge7", 32'(s0), 32'h1);
        repeat (20) tick();
        key_n[0] = 1'b1;
        repeat (D + 5) tick();
        check_eq("ar_rel_once", 32'(s0), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
